// File: rtl/serial_subtractor_if.sv
// Operand/result bundle for the bit-serial subtractor.
// The master supplies start and the operands; the slave returns status and the held result.
interface serial_subtractor_if #(
    parameter int WIDTH = 4
);
    logic             start;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             bin;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] diff;
    logic             bout;

    modport master (
        output start, a, b, bin,
        input  busy, done, diff, bout
    );

    modport slave (
        input  start, a, b, bin,
        output busy, done, diff, bout
    );
endinterface

// File: rtl/serial_subtractor.sv
// Bit-serial subtractor: diff = a - b - bin, one bit per clock, LSB first.
// A single full-subtractor cell is reused every cycle, with the borrow held in a flop.
module serial_subtractor #(
    parameter int WIDTH = 4
) (
    input  logic                clk,
    input  logic                rst_n,
    serial_subtractor_if.slave  bus
);
    localparam int CW = (WIDTH > 2) ? $clog2(WIDTH) : 1;

    localparam logic [0:0] IDLE = 1'b0;
    localparam logic [0:0] RUN  = 1'b1;

    logic [0:0]       state_reg;
    logic [WIDTH-1:0] a_sh_reg;
    logic [WIDTH-1:0] b_sh_reg;
    logic             br_reg;
    logic [CW-1:0]    cnt_reg;
    logic [WIDTH-1:0] res_reg;
    logic [WIDTH-1:0] diff_reg;
    logic             bout_reg;
    logic             done_reg;

    logic             a0;
    logic             b0;
    logic             d_bit;
    logic             br_next;
    logic             last_bit;
    logic [WIDTH-1:0] res_next;
    logic [WIDTH-1:0] a_sh_next;
    logic [WIDTH-1:0] b_sh_next;

    // Full-subtractor cell on the current LSBs.
    assign a0       = a_sh_reg[0];
    assign b0       = b_sh_reg[0];
    assign d_bit    = a0 ^ b0 ^ br_reg;
    assign br_next  = (~a0 & b0) | (~(a0 ^ b0) & br_reg);
    assign last_bit = (cnt_reg == CW'(WIDTH - 1));

    // Result fills from the MSB end so the LSB computed first ends up at bit 0.
    assign res_next[WIDTH-1]  = d_bit;
    assign a_sh_next[WIDTH-1] = 1'b0;
    assign b_sh_next[WIDTH-1] = 1'b0;
    generate
        for (genvar gi = 0; gi < WIDTH - 1; gi++) begin : g_shift
            assign res_next[gi]  = res_reg[gi+1];
            assign a_sh_next[gi] = a_sh_reg[gi+1];
            assign b_sh_next[gi] = b_sh_reg[gi+1];
        end
    endgenerate

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg <= IDLE;
            a_sh_reg  <= '0;
            b_sh_reg  <= '0;
            br_reg    <= 1'b0;
            cnt_reg   <= '0;
            res_reg   <= '0;
            diff_reg  <= '0;
            bout_reg  <= 1'b0;
            done_reg  <= 1'b0;
        end else begin
            done_reg <= 1'b0;
            case (state_reg)
                IDLE: begin
                    if (bus.start) begin
                        a_sh_reg  <= bus.a;
                        b_sh_reg  <= bus.b;
                        br_reg    <= bus.bin;
                        cnt_reg   <= '0;
                        res_reg   <= '0;
                        state_reg <= RUN;
                    end
                end
                RUN: begin
                    a_sh_reg <= a_sh_next;
                    b_sh_reg <= b_sh_next;
                    br_reg   <= br_next;
                    res_reg  <= res_next;
                    if (last_bit) begin
                        diff_reg  <= res_next;
                        bout_reg  <= br_next;
                        done_reg  <= 1'b1;
                        cnt_reg   <= '0;
                        state_reg <= IDLE;
                    end else begin
                        cnt_reg <= cnt_reg + 1'b1;
                    end
                end
                default: state_reg <= IDLE;
            endcase
        end
    end

    assign bus.busy = (state_reg == RUN);
    assign bus.done = done_reg;
    assign bus.diff = diff_reg;
    assign bus.bout = bout_reg;
endmodule

// File: tb/tb_serial_subtractor.sv
// Self-checking bench for serial_subtractor: directed scenarios plus random operations
// compared against a plain-arithmetic reference model.
module tb_serial_subtractor;
    localparam int W = 4;

    logic clk;
    logic rst_n;
    int   errors;
    int   checks;
    int   cycle_cnt;
    logic [W-1:0] prev_diff;
    logic         prev_bout;

    serial_subtractor_if #(.WIDTH(W)) bus ();

    serial_subtractor #(.WIDTH(W)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cycle_cnt <= cycle_cnt + 1;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    // Reference: signed difference, wrapped to W bits; borrow means it went negative.
    task automatic model(input int av, input int bv, input int biv,
                         output logic [W-1:0] d, output logic bo);
        int r;
        r  = av - bv - biv;
        d  = W'(r & ((1 << W) - 1));
        bo = (r < 0);
    endtask

    // Call at #1 after an edge with the DUT idle.
    task automatic run_op(input int av, input int bv, input int biv);
        logic [W-1:0] ed;
        logic         eb;
        model(av, bv, biv, ed, eb);
        bus.a = W'(av); bus.b = W'(bv); bus.bin = biv[0]; bus.start = 1'b1;
        @(posedge clk); #1;
        bus.start = 1'b0;
        chk("accept_busy", bus.busy, 1);
        chk("accept_done", bus.done, 0);
        for (int i = 1; i < W; i++) begin
            bus.a = W'($urandom); bus.b = W'($urandom); bus.bin = 1'($urandom);
            @(posedge clk); #1;
            chk("run_busy", bus.busy, 1);
            chk("run_done", bus.done, 0);
            chk("run_diff_held", bus.diff, prev_diff);
            chk("run_bout_held", bus.bout, prev_bout);
        end
        @(posedge clk); #1;
        chk("done_pulse", bus.done, 1);
        chk("done_busy", bus.busy, 0);
        chk("diff", bus.diff, ed);
        chk("bout", bus.bout, eb);
        $display("op a=%0d b=%0d bin=%0d -> diff=%0d bout=%0d (exp %0d/%0d)",
                 av, bv, biv, bus.diff, bus.bout, ed, eb);
        prev_diff = ed;
        prev_bout = eb;
        @(posedge clk); #1;
        chk("after_done", bus.done, 0);
    endtask

    initial begin
        int t1;
        errors = 0; checks = 0; cycle_cnt = 0;
        prev_diff = '0; prev_bout = 1'b0;
        bus.start = 1'b0; bus.a = '0; bus.b = '0; bus.bin = 1'b0;
        rst_n = 1'b0;

        // Reset then idle
        repeat (3) @(posedge clk);
        @(negedge clk) rst_n = 1'b1;
        for (int i = 0; i < 10; i++) begin
            @(posedge clk); #1;
            chk("idle_busy", bus.busy, 0);
            chk("idle_done", bus.done, 0);
            chk("idle_diff", bus.diff, 0);
            chk("idle_bout", bus.bout, 0);
        end

        // Basic and borrow cases
        run_op(9, 3, 0);
        run_op(3, 9, 0);
        run_op(0, 0, 1);
        run_op(5, 5, 0);
        run_op(15, 0, 0);
        run_op(0, 15, 1);

        // Back-to-back with start held high
        bus.a = 4'd12; bus.b = 4'd4; bus.bin = 1'b1; bus.start = 1'b1;
        @(posedge clk); #1;
        chk("b2b_accept1", bus.busy, 1);
        bus.a = 4'd7; bus.b = 4'd2; bus.bin = 1'b0;
        repeat (W) @(posedge clk);
        #1;
        t1 = cycle_cnt;
        chk("b2b_done1", bus.done, 1);
        chk("b2b_diff1", bus.diff, 7);
        chk("b2b_bout1", bus.bout, 0);
        $display("b2b first -> diff=%0d bout=%0d", bus.diff, bus.bout);
        @(posedge clk); #1;
        chk("b2b_accept2", bus.busy, 1);
        chk("b2b_done_low", bus.done, 0);
        bus.start = 1'b0;
        repeat (W) @(posedge clk);
        #1;
        chk("b2b_done2", bus.done, 1);
        chk("b2b_gap", cycle_cnt - t1, W + 1);
        chk("b2b_diff2", bus.diff, 5);
        chk("b2b_bout2", bus.bout, 0);
        $display("b2b second -> diff=%0d bout=%0d", bus.diff, bus.bout);
        @(posedge clk); #1;

        // Busy protection
        bus.a = 4'd8; bus.b = 4'd1; bus.bin = 1'b0; bus.start = 1'b1;
        @(posedge clk); #1;
        bus.start = 1'b0;
        @(posedge clk); #1;
        bus.a = 4'd15; bus.b = 4'd15; bus.bin = 1'b1; bus.start = 1'b1;
        @(posedge clk); #1;
        chk("prot_busy", bus.busy, 1);
        bus.a = 4'd3; bus.b = 4'd10;
        @(posedge clk); #1;
        bus.start = 1'b0;
        @(posedge clk); #1;
        chk("prot_done", bus.done, 1);
        chk("prot_diff", bus.diff, 7);
        chk("prot_bout", bus.bout, 0);
        $display("busy-protect -> diff=%0d bout=%0d", bus.diff, bus.bout);
        @(posedge clk); #1;
        chk("prot_no_retrig", bus.busy, 0);
        chk("prot_single_done", bus.done, 0);

        // Reset mid-operation
        bus.a = 4'd9; bus.b = 4'd3; bus.bin = 1'b0; bus.start = 1'b1;
        @(posedge clk); #1;
        bus.start = 1'b0;
        @(posedge clk);
        @(posedge clk); #3;
        rst_n = 1'b0;
        #1;
        chk("rst_busy", bus.busy, 0);
        chk("rst_done", bus.done, 0);
        chk("rst_diff", bus.diff, 0);
        chk("rst_bout", bus.bout, 0);
        $display("mid-op reset applied");
        prev_diff = '0; prev_bout = 1'b0;
        @(negedge clk) rst_n = 1'b1;
        @(posedge clk); #1;
        run_op(6, 2, 0);

        // Random operations
        for (int n = 0; n < 40; n++) begin
            run_op(int'($urandom_range(0, (1 << W) - 1)),
                   int'($urandom_range(0, (1 << W) - 1)),
                   int'($urandom_range(0, 1)));
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
